fib_bcd_converter: RTL and testbench
====================================

FIB_BCD_CONVERTER -- requirements
Module: fib_bcd_converter

Interface
REQ-001 Parameters: none; input width fixed at 8 bits, output fixed at 3 BCD digits.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  in_value holds a new sequence term.
REQ-005 in_value  input  8  unsigned term from the Fibonacci generator output.
REQ-006 in_ready  output  1  block can accept a term this cycle.
REQ-007 out_valid  output  1  bcd holds a converted result.
REQ-008 out_ready  input  1  consumer accepts bcd this cycle.
REQ-009 bcd  output  12  {hundreds, tens, ones}, 4 bits each.
REQ-010 ovf  output  1  sticky wrap-detected flag (see Configuration).

Function
REQ-011 FSM states: IDLE, SHIFT, DONE; exactly one active at any time.
REQ-012 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready edge, latch in_value, clear the 12-bit scratch, load bit counter to 8, go to SHIFT.
REQ-013 SHIFT: in_ready=0, out_valid=0; each edge applies double-dabble: every scratch digit >=5 gets +3, then {scratch,operand} shifts left 1, counter decrements.
REQ-014 SHIFT to DONE on the edge where the counter reaches 0, i.e. exactly 8 edges after the accepting edge.
REQ-015 DONE: out_valid=1, bcd=scratch, in_ready=0; bcd and out_valid stable while out_ready=0 (unbounded back-pressure).
REQ-016 DONE to IDLE on the out_valid&out_ready edge; bcd keeps its last value in IDLE/SHIFT but is only meaningful when out_valid=1.
REQ-017 Throughput: one term per 10 cycles minimum (accept, 8 shift, 1 handoff); no input accepted in SHIFT or DONE.
REQ-018 Digit-adjust arithmetic is 4-bit per digit; hundreds digit never exceeds 2 for 8-bit input; no carry out of bcd.
REQ-019 in_valid asserted while in_ready=0 is ignored; the term is not captured and no error is raised.
REQ-020 in_valid and out_ready both high in DONE: output handoff only; the input is taken no earlier than the next IDLE cycle.

Reset
REQ-021 rst=1 on an edge forces IDLE, bcd=12'h000, counter=0, scratch=0, ovf=0, prev-term register=0 regardless of state.
REQ-022 rst mid-SHIFT or mid-DONE abandons the conversion; no out_valid pulse follows.
REQ-023 rst has priority over every handshake on the same edge.
REQ-024 After reset: in_ready=1, out_valid=0 on the first cycle with rst=0.

Configuration
REQ-025 Macro FIB_BCD_OVF_EN selects wrap detection.
REQ-026 Defined: each accepted term is compared against the previous accepted term; term < previous sets ovf=1 on the accepting edge, sticky until rst.
REQ-027 Defined: the first term after reset never sets ovf; equal terms (1,1) do not set ovf.
REQ-028 Undefined: ovf is constant 0, and no prev-term register or comparator is built.
REQ-029 Conversion timing and handshake are identical with and without the macro.

Verification
REQ-030 Reset, in_value=0, out_ready=1 -> out_valid exactly 8 edges after accept, bcd=12'h000, then in_ready=1 the next cycle.
REQ-031 in_value=255 -> bcd=12'h255; in_value=233 -> bcd=12'h233; in_value=13 -> bcd=12'h013.
REQ-032 Feed 89 with out_ready=0 for 20 cycles -> out_valid held, bcd=12'h089 stable, in_ready=0 throughout, in_valid pulses ignored.
REQ-033 Assert rst at the 4th SHIFT edge -> next cycle IDLE, in_ready=1, bcd=0, no out_valid.
REQ-034 FIB_BCD_OVF_EN defined, feed 0,1,1,2,...,144,233,121 -> ovf=0 through 233, ovf=1 from the 121 accept onward until rst; undefined -> ovf=0 throughout.
REQ-035 Back-to-back: in_valid held high with 10 terms -> each term converted in order, one accept per 10 cycles, no term dropped or duplicated.

Source files
------------

// File: rtl/fib_bcd_converter.sv
// Serial 8-bit binary to 3-digit BCD converter (double-dabble, one bit per clock).
// Optional wrap detection on the incoming term stream: define FIB_BCD_OVF_EN.
module fib_bcd_converter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_value,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [11:0] bcd,
  output logic        ovf
);
  // state | meaning
  // IDLE  | waiting for a term, in_ready high
  // SHIFT | eight double-dabble steps in progress
  // DONE  | result presented on bcd, waiting for out_ready
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  operand;
  logic [11:0] scratch;
  logic [11:0] scratch_adj;
  logic [3:0]  cnt;
  logic        accept;

  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = SHIFT;
      SHIFT:   if (cnt == 4'd1)   state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Per-digit +3 correction ahead of the shift; 4-bit arithmetic, no inter-digit carry.
  always_comb begin
    for (int d = 0; d < 3; d++) begin
      scratch_adj[d*4 +: 4] = (scratch[d*4 +: 4] >= 4'd5) ? scratch[d*4 +: 4] + 4'd3
                                                          : scratch[d*4 +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      operand <= 8'h00;
      scratch <= 12'h000;
      cnt     <= 4'd0;
      bcd     <= 12'h000;
    end else if (accept) begin
      operand <= in_value;
      scratch <= 12'h000;
      cnt     <= 4'd8;
    end else if (state == SHIFT) begin
      {scratch, operand} <= {scratch_adj, operand} << 1;
      cnt                <= cnt - 4'd1;
      // bcd only updates with the final shifted value, so it holds through IDLE/SHIFT.
      if (cnt == 4'd1) bcd <= {scratch_adj[10:0], operand[7]};
    end
  end

`ifdef FIB_BCD_OVF_EN
  logic [7:0] prev_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_term <= 8'h00;
      ovf       <= 1'b0;
    end else if (accept) begin
      prev_term <= in_value;
      if (in_value < prev_term) ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fib_bcd_converter.sv
// Scoreboard bench for fib_bcd_converter: directed cases plus randomized traffic
// checked against an arithmetic decimal-digit model.
module tb_fib_bcd_converter;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_value;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid;
  logic [11:0] bcd;
  logic        ovf;

  fib_bcd_converter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
    .bcd(bcd), .ovf(ovf)
  );

`ifdef FIB_BCD_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [11:0] b;
    logic        o;
    int          v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // monitor-side model and bookkeeping
  int          m_prev;
  bit          m_ovf;
  bit          prev_ov;
  bit          hold_v;
  logic [11:0] hold_bcd;
  int          acc_cyc;
  int          last_acc;
  bit          have_last;
  bit          b2b = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_prev    = 0;
      m_ovf     = 1'b0;
      prev_ov   = 1'b0;
      hold_v    = 1'b0;
      have_last = 1'b0;
    end else begin
      if (hold_v) begin
        check(out_valid == 1'b1, "hold_valid", 32'(out_valid), 32'd1);
        check(bcd == hold_bcd, "hold_bcd", 32'(bcd), 32'(hold_bcd));
      end
      if (out_valid) check(in_ready == 1'b0, "ready_while_valid", 32'(in_ready), 32'd0);
      if (out_valid && !prev_ov)
        check(cyc - acc_cyc == 9, "latency", 32'(cyc - acc_cyc), 32'd9);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check(1'b0, "unexpected_output", 32'(bcd), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check(bcd == e.b, "bcd", 32'(bcd), 32'(e.b));
          check(ovf == e.o, "ovf", 32'(ovf), 32'(e.o));
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        if (OVF_EN && int'(in_value) < m_prev) m_ovf = 1'b1;
        m_prev = int'(in_value);
        e.b = ref_bcd(int'(in_value));
        e.o = m_ovf;
        e.v = int'(in_value);
        q.push_back(e);
        if (b2b && have_last)
          check(cyc - last_acc == 10, "b2b_spacing", 32'(cyc - last_acc), 32'd10);
        acc_cyc   = cyc;
        last_acc  = cyc;
        have_last = 1'b1;
      end
      if (!b2b) have_last = 1'b0;
      hold_v   = out_valid && !out_ready;
      hold_bcd = bcd;
      prev_ov  = out_valid;
    end
  end

  task automatic send(input logic [7:0] v, input bit hold);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_value = v;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) check(1'b0, "accept_timeout", 32'(v), 32'd0);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) check(1'b0, "drain_timeout", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [7:0] fib [15];
    logic [7:0] directed [4];
    bit seen;
    fib      = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
                 8'd55, 8'd89, 8'd144, 8'd233, 8'd121};
    directed = '{8'd0, 8'd255, 8'd233, 8'd13};

    rst = 1'b1; in_valid = 1'b0; in_value = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(in_ready == 1'b1, "rst_in_ready", 32'(in_ready), 32'd1);
    check(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
    check(bcd == 12'h000, "rst_bcd", 32'(bcd), 32'h000);
    check(ovf == 1'b0, "rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;

    foreach (directed[i]) begin
      send(directed[i], 1'b0);
      drain();
    end

    // back-pressure with ignored input pulses
    out_ready = 1'b0;
    send(8'd89, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) check(1'b0, "hold_valid_timeout", 32'(out_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid = i[0];
      in_value = 8'd7;
      @(negedge clk);
      check(in_ready == 1'b0, "bp_in_ready", 32'(in_ready), 32'd0);
      check(bcd == 12'h089, "bp_bcd", 32'(bcd), 32'h089);
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // reset in the middle of a conversion
    send(8'd200, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(in_ready == 1'b1, "midrst_in_ready", 32'(in_ready), 32'd1);
    check(bcd == 12'h000, "midrst_bcd", 32'(bcd), 32'h000);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check(out_valid == 1'b0, "midrst_no_valid", 32'(out_valid), 32'd0);
    end

    // Fibonacci stream ending in a wrap
    do_reset();
    for (int i = 0; i < 14; i++) begin
      send(fib[i], 1'b0);
      drain();
    end
    check(ovf == 1'b0, "ovf_before_wrap", 32'(ovf), 32'd0);
    send(fib[14], 1'b0);
    @(negedge clk);
    check(ovf == OVF_EN, "ovf_after_wrap", 32'(ovf), 32'(OVF_EN));
    drain();
    check(ovf == OVF_EN, "ovf_sticky", 32'(ovf), 32'(OVF_EN));
    do_reset();
    @(negedge clk);
    check(ovf == 1'b0, "ovf_cleared", 32'(ovf), 32'd0);

    // back-to-back with in_valid held high
    @(posedge clk);
    #1 b2b = 1'b1;
    for (int i = 0; i < 10; i++) send(8'($urandom), i < 9);
    drain();
    b2b = 1'b0;

    // randomized traffic with random back-pressure
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_value  = 8'($urandom);
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b1;
    drain();
    check(q.size() == 0, "final_queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
